sram_1rw_client: RTL and testbench
==================================

// Module: sram_1rw_client
// PURPOSE
//  Requester-side controller for a single-port masked SRAM macro with an RW0_* port and 1-cycle read latency.
//  Turns a valid/ready request stream (read or masked write) into RW0_* strobes.
//  Captures read data the cycle after issue into a response FIFO, so data stays correct under rsp backpressure
//  and under later writes to the same address. Sits between a cache/TLB pipeline and its array macro.
// PARAMETERS
//  ADDR_W     8   SRAM address width (depth = 2**ADDR_W)
//  DATA_W     48  SRAM word width
//  MASK_GRAN  8   bits per write-mask lane; DATA_W % MASK_GRAN == 0
//  MASK_W     DATA_W/MASK_GRAN  derived, not overridable
//  RSP_DEPTH  3   response FIFO entries; >=3 for 1 req/cycle with rsp_ready=1; min 1
// PORTS
//  clock        in   1       sole clock, rising edge
//  reset        in   1       synchronous, active-high
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when valid&&ready
//  req_write    in   1       1=masked write, 0=read
//  req_addr     in   ADDR_W  word address
//  req_mask     in   MASK_W  write lane enables (ignored for reads)
//  req_wdata    in   DATA_W  write data
//  rsp_valid    out  1       response at FIFO head
//  rsp_ready    in   1       consumer takes the head
//  rsp_rdata    out  DATA_W  read data (0 for write acks)
//  rsp_write    out  1       1=write ack (always 0 unless SRAM_CLIENT_WR_ACK_EN)
//  RW0_addr     out  ADDR_W  to macro
//  RW0_en       out  1       to macro
//  RW0_wmode    out  1       to macro
//  RW0_wmask    out  MASK_W  to macro
//  RW0_wdata    out  DATA_W  to macro
//  RW0_rdata    in   DATA_W  from macro; valid only the cycle after a read strobe
// BEHAVIOUR
//  - Reset (sync): occ=0, inflight=0, FIFO pointers=0. req_ready=0 and RW0_en=0 while reset is high.
//    rsp_valid=0 the cycle after reset is sampled. Any in-flight read is discarded.
//  - req_ready = !reset && (occ + inflight < RSP_DEPTH). Registered terms only; no comb path from rsp_ready
//    or req_valid to req_ready.
//  - Fire: RW0_en = req_valid && req_ready, same cycle, combinational. RW0_wmode = req_write.
//    RW0_addr/RW0_wmask/RW0_wdata are direct pass-through.
//  - inflight <= fire && (!req_write || WR_ACK). It is a credit, so a push never finds the FIFO full.
//  - Cycle after a read fire: push {rdata=RW0_rdata, write=0}. RW0_rdata is sampled only in this cycle.
//    Latency is fire -> rsp_valid = 2 cycles when the FIFO was empty.
//  - Pop on rsp_valid && rsp_ready. Push and pop in the same cycle leave occ unchanged. Pointers wrap modulo RSP_DEPTH.
//  - Responses return in request order. Writes never reorder relative to reads at the macro.
//  - Read then write, same addr, back-to-back: the read returns the pre-write data. It is captured before the write edge lands.
//  - rsp_valid/rsp_rdata/rsp_write hold stable while rsp_valid && !rsp_ready.
//  - Full: occ+inflight == RSP_DEPTH -> req_ready=0 and RW0_en=0. A pop in that cycle raises req_ready the next cycle.
//  - An empty mask write still strobes RW0_en (the macro ignores it). With WR_ACK it is still acknowledged.
// CONFIGURATION
//  SRAM_CLIENT_WR_ACK_EN defined:
//    Every write also takes a credit and pushes {rdata=0, write=1} the cycle after fire, in order with reads.
//  Undefined:
//    Writes need no credit but still obey req_ready. They produce no response. rsp_write is tied 0.
// STRUCTURE
//  - Package sram_client_pkg: default ADDR_W/DATA_W/MASK_GRAN/RSP_DEPTH constants and the rsp_entry_t struct
//    {logic write; logic [DATA_W-1:0] rdata}.
//  - Sub-module sram_rsp_fifo: parameterised synchronous FIFO with a push-never-full assertion.
//    Top level holds the credit/inflight logic and the RW0 drive.
// TESTING (bench includes a behavioural 256x48 mask-8 macro model)
//  - Reset mid-read: fire a read of addr 0x10, assert reset next cycle -> no response ever; rsp_valid=0 and
//    req_ready=0 during reset.
//  - Masked write: wdata=0xAAAA_BBBB_CCCC, mask=6'b000101 to 0x3F over an old value of 0 -> read 0x3F returns
//    0x0000_00BB_00CC; read response 2 cycles after the read fire.
//  - Streaming: 16 reads, addr 0..15, rsp_ready=1 -> req_ready stays 1. 16 responses on consecutive cycles, in order.
//  - Backpressure: rsp_ready=0, issue reads -> exactly 3 accepted, then req_ready=0. Head data is stable.
//    Release rsp_ready -> remaining responses drain in order.
//  - Hazard: read 0x20 (holds 0x1111), then write 0x20=0x2222 next cycle, with rsp_ready=0 for 5 cycles
//    -> response is 0x1111.
//  - WR_ACK_EN: write 0x05 then read 0x05 -> rsp sequence {write=1,rdata=0} then {write=0,rdata=new value}.
//    Without the macro: only the read response.

Source files
------------

// File: rtl/sram_client_pkg.sv
// Shared defaults and types for the 1RW SRAM requester client and its response FIFO.
// Parameter defaults describe a 256 x 48 macro with 8-bit write-mask lanes.
package sram_client_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 48;
    localparam int DEF_MASK_GRAN = 8;
    localparam int DEF_RSP_DEPTH = 3;

    typedef struct packed {
        logic                  write;
        logic [DEF_DATA_W-1:0] rdata;
    } rsp_entry_t;

    // A one-entry FIFO still needs a 1-bit pointer to stay a legal vector.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO with modulo-DEPTH pointers and an occupancy count.
// The producer is credit-limited, so a push into a full FIFO is a design error.
module sram_rsp_fifo
    import sram_client_pkg::*;
#(
    parameter int   WIDTH = 49,
    parameter int   DEPTH = 3,
    localparam int  PTR_W = ptr_width(DEPTH),
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= bump(wr_ptr);
            if (pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= push_data;
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (count != '0);
    assign full       = (count == CNT_W'(DEPTH));

    push_never_full: assert property (@(posedge clock) disable iff (reset) !(push && full));
    pop_never_empty: assert property (@(posedge clock) disable iff (reset) !(pop && !head_valid));

endmodule

// File: rtl/sram_1rw_client.sv
// Valid/ready front end for a single-port masked SRAM macro with 1-cycle read latency.
// Define SRAM_CLIENT_WR_ACK_EN to return an in-order acknowledgement for every write.
module sram_1rw_client
    import sram_client_pkg::*;
#(
    parameter int  ADDR_W    = DEF_ADDR_W,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  MASK_GRAN = DEF_MASK_GRAN,
    parameter int  RSP_DEPTH = DEF_RSP_DEPTH,
    localparam int MASK_W    = DATA_W / MASK_GRAN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_write,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [MASK_W-1:0] RW0_wmask,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

`ifdef SRAM_CLIENT_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic              write;
        logic [DATA_W-1:0] rdata;
    } entry_t;

    logic             fire;
    logic             inflight;
    logic             inflight_write;
    logic [CNT_W-1:0] occ;
    logic [CNT_W:0]   credits_used;
    entry_t           push_entry;
    entry_t           head_entry;
    logic             pop;

    // Credits count both queued entries and the one whose data is still on the macro bus.
    assign credits_used = {1'b0, occ} + (CNT_W + 1)'(inflight);
    assign req_ready    = !reset && (credits_used < (CNT_W + 1)'(RSP_DEPTH));
    assign fire         = req_valid && req_ready;

    assign RW0_en    = fire;
    assign RW0_wmode = req_write;
    assign RW0_addr  = req_addr;
    assign RW0_wmask = req_mask;
    assign RW0_wdata = req_wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            inflight       <= 1'b0;
            inflight_write <= 1'b0;
        end else begin
            inflight       <= fire && (!req_write || WR_ACK);
            inflight_write <= fire && req_write && WR_ACK;
        end
    end

    // Read data is valid only now, so it is captured before any following write edge lands.
    assign push_entry.write = inflight_write;
    assign push_entry.rdata = inflight_write ? '0 : RW0_rdata;

    assign pop = rsp_valid && rsp_ready;

    sram_rsp_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight),
        .push_data  (push_entry),
        .pop        (pop),
        .head_data  (head_entry),
        .head_valid (rsp_valid),
        .count      (occ)
    );

    assign rsp_rdata = head_entry.rdata;
    assign rsp_write = head_entry.write;

endmodule

// File: tb/tb_sram_1rw_client.sv
// Directed bench for sram_1rw_client with a behavioural 256x48, 8-bit-lane masked macro model.
// Expected responses follow SRAM_CLIENT_WR_ACK_EN when it is defined for the build.
module tb_sram_1rw_client;
    import sram_client_pkg::*;

`ifdef SRAM_CLIENT_WR_ACK_EN
    localparam logic ACK = 1'b1;
`else
    localparam logic ACK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [5:0]  req_mask;
    logic [47:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [47:0] rsp_rdata;
    logic        rsp_write;
    logic [7:0]  RW0_addr;
    logic        RW0_en;
    logic        RW0_wmode;
    logic [5:0]  RW0_wmask;
    logic [47:0] RW0_wdata;
    logic [47:0] RW0_rdata;

    int checks;
    int errors;

    always #5 clock = ~clock;

    sram_1rw_client dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_mask  (req_mask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_write (rsp_write),
        .RW0_addr  (RW0_addr),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_wmask (RW0_wmask),
        .RW0_wdata (RW0_wdata),
        .RW0_rdata (RW0_rdata)
    );

    // Macro model: read data registered on the strobe edge, masked byte-lane writes.
    logic [47:0] mem [256];
    logic [47:0] model_rdata;
    assign RW0_rdata = model_rdata;

    always @(posedge clock) begin
        if (RW0_en) begin
            if (RW0_wmode) begin
                for (int l = 0; l < 6; l++)
                    if (RW0_wmask[l]) mem[RW0_addr][l*8 +: 8] <= RW0_wdata[l*8 +: 8];
            end else begin
                model_rdata <= mem[RW0_addr];
            end
        end
    end

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [5:0]  mask;
        logic [47:0] wdata;
        logic [47:0] exp;
    } vec_t;

    vec_t       vecs [9];
    rsp_entry_t exp_rsp;
    int         seen;
    int         accepted;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Drive one request from a negedge until it fires; returns at the next negedge with req_valid low.
    task automatic applyStimulus(input logic wr, input logic [7:0] addr, input logic [5:0] mask,
                                 input logic [47:0] wdata);
        int waited = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = wdata;
        #1;
        while (!req_ready && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        checkOutput("req_accept", req_ready, 1);
        checkOutput("rw0_en", RW0_en, 1);
        checkOutput("rw0_wmode", RW0_wmode, wr);
        checkOutput("rw0_addr", RW0_addr, addr);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    // Response must appear exactly two cycles after the fire (writes only with acks enabled).
    task automatic expectResponse(input logic wr, input logic [47:0] exp);
        logic exp_valid;
        exp_valid = !wr || ACK;
        exp_rsp.write = wr;
        exp_rsp.rdata = wr ? 48'h0 : exp;
        rsp_ready = 1'b1;
        #1;
        checkOutput("lat1_empty", rsp_valid, 0);
        @(negedge clock);
        #1;
        checkOutput("lat2_valid", rsp_valid, exp_valid);
        if (exp_valid) begin
            checkOutput("lat2_rdata", rsp_rdata, exp_rsp.rdata);
            checkOutput("lat2_write", rsp_write, exp_rsp.write);
        end
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_mask  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        for (int i = 0; i < 16; i++) mem[i] <= 48'hC0DE_0000_0000 | 48'(i);
        for (int i = 0; i < 3; i++) mem[8'h40 + i] <= 48'hBEEF_0000_0040 + 48'(i);
        mem[8'h10] <= 48'h0000_0000_0777;
        mem[8'h20] <= 48'h0000_0000_1111;

        vecs[0] = '{1'b1, 8'h3F, 6'b000101, 48'hAAAA_BBBB_CCCC, 48'h0};
        vecs[1] = '{1'b0, 8'h3F, 6'b000000, 48'h0,              48'h0000_00BB_00CC};
        vecs[2] = '{1'b1, 8'h3F, 6'b110000, 48'h1234_5678_9ABC, 48'h0};
        vecs[3] = '{1'b1, 8'h3F, 6'b000000, 48'hFFFF_FFFF_FFFF, 48'h0};
        vecs[4] = '{1'b0, 8'h3F, 6'b000000, 48'h0,              48'h1234_00BB_00CC};
        vecs[5] = '{1'b1, 8'h80, 6'b111111, 48'hDEAD_BEEF_CAFE, 48'h0};
        vecs[6] = '{1'b1, 8'h80, 6'b000010, 48'h0,              48'h0};
        vecs[7] = '{1'b0, 8'h80, 6'b000000, 48'h0,              48'hDEAD_BEEF_00FE};
        vecs[8] = '{1'b0, 8'hFF, 6'b000000, 48'h0,              48'h0};

        // Reset state, including a request offered while reset is high.
        repeat (2) @(negedge clock);
        req_valid = 1'b1;
        req_addr  = 8'h10;
        #1;
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_rw0_en", RW0_en, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);

        // Reset mid-read: the read fires, reset lands next cycle, no response may ever appear.
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midrd_fire", RW0_en, 1);
        @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("midrd_req_ready", req_ready, 0);
        checkOutput("midrd_rw0_en", RW0_en, 0);
        checkOutput("midrd_rsp_valid", rsp_valid, 0);
        @(negedge clock);
        reset     = 1'b0;
        req_valid = 1'b0;
        seen      = 0;
        repeat (6) begin
            @(negedge clock);
            #1;
            if (rsp_valid) seen++;
        end
        checkOutput("midrd_no_rsp", seen, 0);

        // Table of masked writes and reads, one transaction at a time.
        for (int v = 0; v < 9; v++) begin
            @(negedge clock);
            applyStimulus(vecs[v].wr, vecs[v].addr, vecs[v].mask, vecs[v].wdata);
            expectResponse(vecs[v].wr, vecs[v].exp);
        end

        // Streaming reads with the consumer always ready.
        rsp_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            @(negedge clock);
            if (c < 16) begin
                req_valid = 1'b1;
                req_write = 1'b0;
                req_addr  = 8'(c);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (c < 16) checkOutput("stream_ready", req_ready, 1);
            if (c >= 2 && c < 18) begin
                checkOutput("stream_valid", rsp_valid, 1);
                checkOutput("stream_data", rsp_rdata, 48'hC0DE_0000_0000 | 48'(c - 2));
            end
            if (c == 18) checkOutput("stream_end", rsp_valid, 0);
        end

        // Backpressure: only RSP_DEPTH reads get credits, head holds, then drains in order.
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            req_valid = 1'b1;
            req_write = 1'b0;
            req_addr  = 8'h40 + 8'(accepted);
            #1;
            if (req_ready) accepted++;
        end
        checkOutput("bp_accepted", accepted, 3);
        checkOutput("bp_ready_low", req_ready, 0);
        checkOutput("bp_en_low", RW0_en, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            req_valid = 1'b0;
            #1;
            checkOutput("bp_head_valid", rsp_valid, 1);
            checkOutput("bp_head_stable", rsp_rdata, 48'hBEEF_0000_0040);
        end
        @(negedge clock);
        rsp_ready = 1'b1;
        #1;
        checkOutput("bp_ready_still_low", req_ready, 0);
        checkOutput("bp_drain0", rsp_rdata, 48'hBEEF_0000_0040);
        @(negedge clock);
        #1;
        checkOutput("bp_ready_back", req_ready, 1);
        checkOutput("bp_drain1", rsp_rdata, 48'hBEEF_0000_0041);
        @(negedge clock);
        #1;
        checkOutput("bp_drain2", rsp_rdata, 48'hBEEF_0000_0042);
        checkOutput("bp_drain2_valid", rsp_valid, 1);
        @(negedge clock);
        #1;
        checkOutput("bp_empty", rsp_valid, 0);

        // Hazard: read then write to the same word back-to-back under backpressure.
        @(negedge clock);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'h20;
        #1;
        checkOutput("hz_read_fire", RW0_en, 1);
        @(negedge clock);
        req_write = 1'b1;
        req_mask  = 6'h3F;
        req_wdata = 48'h0000_0000_2222;
        #1;
        checkOutput("hz_write_fire", RW0_en, 1);
        checkOutput("hz_write_mode", RW0_wmode, 1);
        @(negedge clock);
        req_valid = 1'b0;
        req_write = 1'b0;
        repeat (4) @(negedge clock);
        #1;
        checkOutput("hz_valid", rsp_valid, 1);
        checkOutput("hz_old_data", rsp_rdata, 48'h0000_0000_1111);
        checkOutput("hz_write_flag", rsp_write, 0);
        rsp_ready = 1'b1;
        @(negedge clock);
        #1;
        checkOutput("hz_ack_valid", rsp_valid, ACK);
        if (rsp_valid) begin
            checkOutput("hz_ack_write", rsp_write, 1);
            checkOutput("hz_ack_rdata", rsp_rdata, 0);
        end
        @(negedge clock);
        applyStimulus(1'b0, 8'h20, 6'h0, 48'h0);
        expectResponse(1'b0, 48'h0000_0000_2222);

        // Write then read of the same word back-to-back, consumer ready.
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h05;
        req_mask  = 6'h3F;
        req_wdata = 48'h5555_6666_7777;
        #1;
        checkOutput("wa_write_fire", RW0_en, 1);
        @(negedge clock);
        req_write = 1'b0;
        #1;
        checkOutput("wa_read_fire", RW0_en, 1);
        checkOutput("wa_read_mode", RW0_wmode, 0);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        checkOutput("wa_first_valid", rsp_valid, ACK);
        checkOutput("wa_first_write", rsp_write, ACK);
        if (rsp_valid) checkOutput("wa_ack_rdata", rsp_rdata, 0);
        @(negedge clock);
        #1;
        checkOutput("wa_read_valid", rsp_valid, 1);
        checkOutput("wa_read_write", rsp_write, 0);
        checkOutput("wa_read_data", rsp_rdata, 48'h5555_6666_7777);
        @(negedge clock);
        #1;
        checkOutput("wa_empty", rsp_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
